// File: rtl/uart_host_ctrl.sv
// Host-side initiator for a UART chip-select register interface: byte stream in, strobes out.
// Define UART_HOST_ERR_CNT_EN to add the saturating PERR_CNT/FERR_CNT error counters.
module uart_host_ctrl #(
   parameter int unsigned GUARD_CYCLES = 2,
   parameter int unsigned RX_PRIORITY  = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       TX_VALID,
   input  logic [7:0] TX_DATA,
   output logic       TX_READY,
   output logic       RX_VALID,
   output logic [7:0] RX_DATA,
   output logic       RX_PERR,
   output logic       RX_FERR,
   input  logic       RX_READY,
   output logic       OVF_SEEN,
   input  logic       CLR_ERR,
`ifdef UART_HOST_ERR_CNT_EN
   output logic [7:0] PERR_CNT,
   output logic [7:0] FERR_CNT,
`endif
   output logic       CSN,
   output logic       WEN,
   output logic       OEN,
   output logic [7:0] DATA_IN,
   input  logic [7:0] DATA_OUT,
   input  logic       TXRDY,
   input  logic       RXRDY,
   input  logic       PARITY_ERR,
   input  logic       FRAMING_ERR,
   input  logic       OVERFLOW
);

   typedef enum logic [1:0] {StIdle, StWr, StRd, StGuard} state_e;

   localparam logic [3:0] GuardLoad = 4'(GUARD_CYCLES);

   state_e     state_q, state_d;
   logic [3:0] guard_cnt_q, guard_cnt_d;
   logic       csn_q, csn_d;
   logic       wen_q, wen_d;
   logic       oen_q, oen_d;
   logic [7:0] data_in_q, data_in_d;
   logic       rx_valid_q, rx_valid_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_perr_q, rx_perr_d;
   logic       rx_ferr_q, rx_ferr_d;
   logic       ovf_q, ovf_d;

   logic rd_req, wr_req;
   logic serve_rd, serve_wr;
   logic capture;

   // A held byte blocks further reads so the UART keeps the data under backpressure.
   assign rd_req  = RXRDY & ~rx_valid_q;
   assign wr_req  = TX_VALID & TXRDY;
   assign capture = (state_q == StRd);

   always_comb begin
      serve_rd = 1'b0;
      serve_wr = 1'b0;
      if (state_q == StIdle) begin
         if (RX_PRIORITY != 0) begin
            serve_rd = rd_req;
            serve_wr = wr_req & ~rd_req;
         end else begin
            serve_wr = wr_req;
            serve_rd = rd_req & ~wr_req;
         end
      end
   end

   assign TX_READY = serve_wr & ~RESET;

   // Strobe levels are computed one cycle ahead so the pins come straight from flops.
   always_comb begin
      state_d     = state_q;
      guard_cnt_d = guard_cnt_q;
      csn_d       = 1'b1;
      wen_d       = 1'b1;
      oen_d       = 1'b1;
      data_in_d   = data_in_q;
      unique case (state_q)
         StIdle: begin
            if (serve_wr) begin
               state_d   = StWr;
               csn_d     = 1'b0;
               wen_d     = 1'b0;
               data_in_d = TX_DATA;
            end else if (serve_rd) begin
               state_d = StRd;
               csn_d   = 1'b0;
               oen_d   = 1'b0;
            end
         end
         StWr, StRd: begin
            state_d     = StGuard;
            guard_cnt_d = GuardLoad;
         end
         StGuard: begin
            guard_cnt_d = guard_cnt_q - 4'd1;
            if (guard_cnt_q <= 4'd1) begin
               state_d     = StIdle;
               guard_cnt_d = 4'd0;
            end
         end
         default: begin
            state_d     = StIdle;
            guard_cnt_d = 4'd0;
         end
      endcase
   end

   always_comb begin
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      if (rx_valid_q && RX_READY) begin
         rx_valid_d = 1'b0;
      end
      if (capture) begin
         rx_valid_d = 1'b1;
         rx_data_d  = DATA_OUT;
         rx_perr_d  = PARITY_ERR;
         rx_ferr_d  = FRAMING_ERR;
      end
   end

   // A fresh overflow beats a simultaneous clear.
   assign ovf_d = OVERFLOW | (ovf_q & ~CLR_ERR);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= StIdle;
         guard_cnt_q <= 4'd0;
         csn_q       <= 1'b1;
         wen_q       <= 1'b1;
         oen_q       <= 1'b1;
         data_in_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_perr_q   <= 1'b0;
         rx_ferr_q   <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         guard_cnt_q <= guard_cnt_d;
         csn_q       <= csn_d;
         wen_q       <= wen_d;
         oen_q       <= oen_d;
         data_in_q   <= data_in_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
         rx_perr_q   <= rx_perr_d;
         rx_ferr_q   <= rx_ferr_d;
         ovf_q       <= ovf_d;
      end
   end

   assign CSN      = csn_q;
   assign WEN      = wen_q;
   assign OEN      = oen_q;
   assign DATA_IN  = data_in_q;
   assign RX_VALID = rx_valid_q;
   assign RX_DATA  = rx_data_q;
   assign RX_PERR  = rx_perr_q;
   assign RX_FERR  = rx_ferr_q;
   assign OVF_SEEN = ovf_q;

`ifdef UART_HOST_ERR_CNT_EN
   logic [7:0] perr_cnt_q, perr_cnt_d;
   logic [7:0] ferr_cnt_q, ferr_cnt_d;

   // Clear beats a same-cycle increment; both counters saturate at 255.
   always_comb begin
      perr_cnt_d = perr_cnt_q;
      ferr_cnt_d = ferr_cnt_q;
      if (CLR_ERR) begin
         perr_cnt_d = 8'd0;
         ferr_cnt_d = 8'd0;
      end else if (capture) begin
         if (PARITY_ERR && (perr_cnt_q != 8'hFF)) begin
            perr_cnt_d = perr_cnt_q + 8'd1;
         end
         if (FRAMING_ERR && (ferr_cnt_q != 8'hFF)) begin
            ferr_cnt_d = ferr_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         perr_cnt_q <= 8'd0;
         ferr_cnt_q <= 8'd0;
      end else begin
         perr_cnt_q <= perr_cnt_d;
         ferr_cnt_q <= ferr_cnt_d;
      end
   end

   assign PERR_CNT = perr_cnt_q;
   assign FERR_CNT = ferr_cnt_q;
`endif

endmodule

// File: doc/uart_host_ctrl.md
Name: uart_host_ctrl

Overview:
- Host-side initiator for the UART chip-select register interface (CSN/WEN/OEN, DATA_IN/DATA_OUT, TXRDY/RXRDY, error flags).
- Converts a user-side valid/ready byte stream into UART write strobes.
- Drains received bytes via UART read strobes into a one-entry output buffer.
- Sits between a local sequencer/CPU-less datapath and the UART core instance.

Parameters:
GUARD_CYCLES, 2, idle cycles with CSN high after every strobe before TXRDY/RXRDY are re-sampled; legal 1..15.
RX_PRIORITY, 1, 1 = a pending read wins over a pending write in IDLE; 0 = write wins.

Ports:
CLK  in  1  single clock, rising-edge.
RESET  in  1  asynchronous, active-high reset.
TX_VALID  in  1  user byte to transmit is valid.
TX_DATA  in  8  user byte to transmit.
TX_READY  out  1  byte accepted when TX_VALID & TX_READY.
RX_VALID  out  1  received byte held in output buffer.
RX_DATA  out  8  received byte.
RX_PERR  out  1  parity error captured with RX_DATA.
RX_FERR  out  1  framing error captured with RX_DATA.
RX_READY  in  1  user consumes buffer when RX_VALID & RX_READY.
OVF_SEEN  out  1  sticky: UART OVERFLOW seen high.
CLR_ERR  in  1  clears OVF_SEEN (and counters, see optional feature).
CSN  out  1  UART chip select, active-low.
WEN  out  1  UART write strobe, active-low.
OEN  out  1  UART read strobe, active-low.
DATA_IN  out  8  byte driven to UART.
DATA_OUT  in  8  byte from UART.
TXRDY  in  1  UART can accept a byte.
RXRDY  in  1  UART holds a received byte.
PARITY_ERR  in  1  UART parity error flag.
FRAMING_ERR  in  1  UART framing error flag.
OVERFLOW  in  1  UART overflow flag.

Behaviour:
- One clock domain, CLK. Reset is asynchronous and active-high on RESET.
- Reset values: CSN=WEN=OEN=1, DATA_IN=0, RX_VALID=0, RX_DATA=0, RX_PERR=RX_FERR=0, OVF_SEEN=0, FSM=IDLE, guard counter=0.
- CSN/WEN/OEN/DATA_IN are registered, glitch-free. Reset asserted mid-strobe forces CSN/WEN/OEN high immediately (asynchronous).
- rd_req = RXRDY & !RX_VALID.
- wr_req = TX_VALID & TXRDY.
- FSM states: IDLE, WR, RD, GUARD.
- IDLE:
  - If both rd_req and wr_req are set, RX_PRIORITY selects which one is served.
  - rd_req served: next state RD.
  - wr_req served: TX_READY=1 combinationally, TX_DATA latched into DATA_IN, next state WR.
  - TX_READY is 0 in every state other than IDLE.
- WR: exactly 1 cycle with CSN=0, WEN=0, OEN=1. Next state GUARD, counter loaded with GUARD_CYCLES.
- RD: exactly 1 cycle with CSN=0, OEN=0, WEN=1.
  - On the closing edge, capture DATA_OUT, PARITY_ERR, FRAMING_ERR into RX_DATA/RX_PERR/RX_FERR and set RX_VALID.
  - Next state GUARD, counter loaded with GUARD_CYCLES.
- GUARD: CSN=1. Counter decrements each cycle. At 1, next state IDLE.
- Latency:
  - TX_VALID&TX_READY at cycle N: WEN low during N+1, next TX_READY no earlier than N+2+GUARD_CYCLES.
  - RXRDY seen in IDLE at cycle N: OEN low during N+1, RX_VALID high from N+2.
- RX_VALID stays set until RX_VALID&RX_READY, then clears on that edge. While set, no read is issued, so UART-side backpressure leaves the data in the UART.
- A consume and a new capture cannot occur in the same cycle: capture only happens in RD, and RD is entered only with RX_VALID=0.
- OVF_SEEN sets on any cycle OVERFLOW=1. CLR_ERR clears it. If both occur in the same cycle, set wins.
- WEN and OEN are never low in the same cycle. A strobe never exceeds 1 cycle.
- TX_DATA changing after acceptance has no effect: DATA_IN holds the latched value.

Optional Feature:
- Macro UART_HOST_ERR_CNT_EN.
- Defined:
  - Adds outputs PERR_CNT[7:0] and FERR_CNT[7:0], reset 0.
  - Each RD capture with PARITY_ERR=1 (respectively FRAMING_ERR=1) increments the counter, saturating at 255.
  - CLR_ERR clears both counters. If an increment and CLR_ERR occur in the same cycle, clear wins.
- Undefined: ports and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then TXRDY=1, TX_VALID=1, TX_DATA=0x5A for one cycle. Required: TX_READY high that cycle; next cycle CSN=0, WEN=0, DATA_IN=0x5A; then CSN=1 for 2 cycles; TX_READY 0 throughout.
- RXRDY=1, DATA_OUT=0xC3, RX_READY=0. Required: OEN low for exactly 1 cycle; RX_VALID=1, RX_DATA=0xC3 two cycles after RXRDY is seen; no second OEN while RX_VALID=1; RX_READY=1 clears RX_VALID next edge.
- RXRDY=1 and TX_VALID&TXRDY=1 in the same cycle with RX_PRIORITY=1. Required: read strobe first, then write strobe after GUARD; with RX_PRIORITY=0 the order is reversed.
- Pulse OVERFLOW=1 for 1 cycle. Required: OVF_SEEN=1 and held. Assert CLR_ERR and OVERFLOW together: OVF_SEEN stays 1. CLR_ERR alone: OVF_SEEN=0.
- Assert RESET during the WR cycle. Required: WEN and CSN high before the next clock edge; FSM in IDLE after deassert; TX_READY not asserted until TXRDY is sampled again.
- UART_HOST_ERR_CNT_EN defined, 300 reads with PARITY_ERR=1. Required: PERR_CNT=255 and FERR_CNT=0; CLR_ERR returns both to 0.
